// File: rtl/vdu_pkg.sv
// Shared definitions for the VDU vertical timing block.
//   vstate_e  : vertical display state (blanked or showing character rows)
//   DEF_*     : default timing constants (14-line rows, 16 visible rows,
//               22-row 50 Hz frame, 19-row 60 Hz frame)
//   max_u     : elaboration-time helper for sizing the row counter
package vdu_pkg;

  typedef enum logic {
    VBLANK = 1'b0,
    ACTIVE = 1'b1
  } vstate_e;

  localparam int unsigned DEF_LINES_PER_ROW = 14;
  localparam int unsigned DEF_VIS_ROWS      = 16;
  localparam int unsigned DEF_TOP_BLANK     = 5;
  localparam int unsigned DEF_TOTAL_50      = 22;
  localparam int unsigned DEF_TOTAL_60      = 19;
  localparam int unsigned DEF_TOP_ROW       = 15;
  localparam int unsigned DEF_VSYNC_ROW     = 1;
  localparam int unsigned DEF_VSYNC_LEN     = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vdu_wrap_cnt.sv
// Wrap-around counter with enable.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   en_i       : advance the count this cycle
//   wrap_i     : last value before returning to 0
//   count_o    : current count
//   carry_o    : high in the enabled cycle that wraps the count to 0
module vdu_wrap_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] count_o,
  output logic         carry_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap_hit;

  // >= rather than == so a count left above a newly shortened wrap value
  // still returns to 0 instead of running around the full range.
  always_comb begin
    wrap_hit = en_i && (count_q >= wrap_i);
    count_d  = count_q;
    if (wrap_hit) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign carry_o = wrap_hit;

endmodule

// File: rtl/vdu_vtiming.sv
// Vertical timing generator for a character-cell video display.
// Counts scanlines within character rows and rows within a frame, advancing
// once per hs_tick, and produces registered blanking/sync/address outputs.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   hs_tick     : one-clk pulse at the end of each scanline
//   mode60      : frame-rate select (1 = 60 Hz), taken at each frame boundary
//   vblank_n    : high while a displayed row is being scanned
//   vsync_n     : low during the vertical sync rows
//   row         : character row address of the displayed row
//   line        : scanline within the displayed row
//   frame_start : one-clk pulse when the frame returns to row 0, line 0
module vdu_vtiming
  import vdu_pkg::*;
#(
  parameter int unsigned LINES_PER_ROW = DEF_LINES_PER_ROW,
  parameter int unsigned VIS_ROWS      = DEF_VIS_ROWS,
  parameter int unsigned TOP_BLANK     = DEF_TOP_BLANK,
  parameter int unsigned TOTAL_50      = DEF_TOTAL_50,
  parameter int unsigned TOTAL_60      = DEF_TOTAL_60,
  parameter int unsigned TOP_ROW       = DEF_TOP_ROW,
  parameter int unsigned VSYNC_ROW     = DEF_VSYNC_ROW,
  parameter int unsigned VSYNC_LEN     = DEF_VSYNC_LEN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hs_tick,
  input  logic                             mode60,
  output logic                             vblank_n,
  output logic                             vsync_n,
  output logic [$clog2(VIS_ROWS)-1:0]      row,
  output logic [$clog2(LINES_PER_ROW)-1:0] line,
  output logic                             frame_start
);

  localparam int unsigned LW = $clog2(LINES_PER_ROW);
  localparam int unsigned VW = $clog2(VIS_ROWS);
  localparam int unsigned RW = $clog2(max_u(TOTAL_50, TOTAL_60));

  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_ROW - 1);
  localparam logic [RW-1:0] WRAP_50   = RW'(TOTAL_50 - 1);
  localparam logic [RW-1:0] WRAP_60   = RW'(TOTAL_60 - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(TOP_BLANK);
  localparam logic [RW-1:0] ROW_END   = RW'(TOP_BLANK + VIS_ROWS);
  localparam logic [VW-1:0] ROW_INIT  = VW'(TOP_ROW % VIS_ROWS);
  localparam logic [VW-1:0] ROW_LAST  = VW'(VIS_ROWS - 1);

  // The display must fit in the longer frame. The shorter (60 Hz) frame may
  // cut the display short; the wrap to row 0 then ends ACTIVE early.
  if ((LINES_PER_ROW < 2) || (LINES_PER_ROW > 32) ||
      (VIS_ROWS < 2) || (VIS_ROWS > 32) ||
      (TOP_BLANK + VIS_ROWS > max_u(TOTAL_50, TOTAL_60))) begin : g_bad_params
    $error("vdu_vtiming: parameter set does not fit the frame");
  end

  logic [LW-1:0] line_cnt;
  logic [LW-1:0] line_next;
  logic          line_carry;
  logic [RW-1:0] row_cnt;
  logic [RW-1:0] row_next;
  logic          row_carry;
  logic [RW-1:0] row_wrap;
  logic [31:0]   row_next_w;

  vstate_e       state_q, state_d;
  logic          mode60_q;
  logic          vblank_n_q, vblank_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic [VW-1:0] row_q, row_d;
  logic [LW-1:0] line_q, line_d;
  logic          frame_start_q, frame_start_d;

  assign row_wrap = mode60_q ? WRAP_60 : WRAP_50;

  vdu_wrap_cnt #(.W(LW)) u_line_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (hs_tick),
    .wrap_i  (LINE_LAST),
    .count_o (line_cnt),
    .carry_o (line_carry)
  );

  vdu_wrap_cnt #(.W(RW)) u_row_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (line_carry),
    .wrap_i  (row_wrap),
    .count_o (row_cnt),
    .carry_o (row_carry)
  );

  // Outputs are registered from the counters' next values so they change
  // in the same clk as the counters themselves.
  always_comb begin
    line_next = line_cnt;
    if (line_carry) begin
      line_next = '0;
    end else if (hs_tick) begin
      line_next = line_cnt + LW'(1);
    end
    row_next = row_cnt;
    if (row_carry) begin
      row_next = '0;
    end else if (line_carry) begin
      row_next = row_cnt + RW'(1);
    end
  end

  assign row_next_w = 32'(row_next);

  always_comb begin
    state_d = state_q;
    if (line_carry) begin
      case (state_q)
        VBLANK: if (row_next == ROW_FIRST) state_d = ACTIVE;
        ACTIVE: if (row_carry || (row_next == ROW_END)) state_d = VBLANK;
      endcase
    end

    vblank_n_d = (state_d == ACTIVE);
    line_d     = '0;
    row_d      = '0;
    if (state_d == ACTIVE) begin
      line_d = line_next;
      // Row address is a separate modulo counter seeded on display entry,
      // avoiding a general modulo of the frame row count.
      if (state_q == VBLANK) begin
        row_d = ROW_INIT;
      end else if (line_carry) begin
        row_d = (row_q == ROW_LAST) ? '0 : row_q + VW'(1);
      end else begin
        row_d = row_q;
      end
    end

    vsync_n_d     = !((row_next_w >= VSYNC_ROW) && (row_next_w < VSYNC_ROW + VSYNC_LEN));
    frame_start_d = row_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= VBLANK;
      mode60_q      <= 1'b0;
      vblank_n_q    <= 1'b0;
      vsync_n_q     <= 1'b1;
      row_q         <= '0;
      line_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (row_carry) begin
        mode60_q <= mode60;
      end
      vblank_n_q    <= vblank_n_d;
      vsync_n_q     <= vsync_n_d;
      row_q         <= row_d;
      line_q        <= line_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vblank_n    = vblank_n_q;
  assign vsync_n     = vsync_n_q;
  assign row         = row_q;
  assign line        = line_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vdu_vtiming.sv
// Bench for vdu_vtiming: default instance checked cycle by cycle against a
// reference model through a scoreboard, plus an alternate 25-row instance.
module tb_vdu_vtiming;

  localparam int LPR = 14;
  localparam int VR  = 16;
  localparam int TB  = 5;
  localparam int T50 = 22;
  localparam int T60 = 19;
  localparam int TR  = 15;
  localparam int VS  = 1;
  localparam int VL  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hs_tick, mode60;
  logic       vblank_n, vsync_n, frame_start;
  logic [3:0] row, line;

  logic       rst2_n, hs2;
  logic       vb2, vs2, fs2;
  logic [4:0] row2;
  logic [3:0] line2;

  vdu_vtiming dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_tick     (hs_tick),
    .mode60      (mode60),
    .vblank_n    (vblank_n),
    .vsync_n     (vsync_n),
    .row         (row),
    .line        (line),
    .frame_start (frame_start)
  );

  vdu_vtiming #(
    .LINES_PER_ROW (10),
    .VIS_ROWS      (25),
    .TOP_BLANK     (3),
    .TOTAL_50      (31),
    .TOP_ROW       (0)
  ) dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .hs_tick     (hs2),
    .mode60      (1'b0),
    .vblank_n    (vb2),
    .vsync_n     (vs2),
    .row         (row2),
    .line        (line2),
    .frame_start (fs2)
  );

  typedef struct packed {
    logic       vb;
    logic       vs;
    logic [3:0] row;
    logic [3:0] line;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_line, m_row;
  bit   m_mode;
  int   rows_q[$];

  function automatic exp_t model_out(input bit fs);
    exp_t e;
    bit   act;
    act    = (m_row >= TB) && (m_row < TB + VR);
    e.vb   = act;
    e.vs   = !((m_row >= VS) && (m_row < VS + VL));
    e.row  = act ? 4'((TR + m_row - TB) % VR) : 4'd0;
    e.line = act ? 4'(m_line) : 4'd0;
    e.fs   = fs;
    return e;
  endfunction

  task automatic model_reset();
    m_line = 0;
    m_row  = 0;
    m_mode = 0;
    sb.delete();
  endtask

  // One clk on the default instance: drive, predict, then compare.
  task automatic sb_cycle(input bit t);
    exp_t e, o;
    bit   wrapped;
    @(negedge clk);
    hs_tick = t;
    wrapped = 0;
    if (t && rst_n) begin
      m_line++;
      if (m_line == LPR) begin
        m_line = 0;
        m_row++;
        if (m_row == (m_mode ? T60 : T50)) begin
          m_row   = 0;
          m_mode  = mode60;
          wrapped = 1;
        end
      end
    end
    sb.push_back(model_out(wrapped));
    @(posedge clk);
    #1;
    o.vb = vblank_n; o.vs = vsync_n; o.row = row; o.line = line; o.fs = frame_start;
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_miss++;
      $display("FAIL sb_outputs @%0t: got vb=%b vs=%b row=%0d line=%0d fs=%b, expected vb=%b vs=%b row=%0d line=%0d fs=%b",
               $time, o.vb, o.vs, o.row, o.line, o.fs, e.vb, e.vs, e.row, e.line, e.fs);
    end
  endtask

  task automatic sync_frame();
    bit found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      sb_cycle(1);
      found = (frame_start === 1'b1);
      sb_cycle(0);
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL sync_frame: no frame_start within 700 lines, required one");
    end
  endtask

  // Starts just after a frame_start line; runs to the next frame_start.
  task automatic measure_frame(output int len, output int vis);
    bit done = 0;
    len = 0;
    vis = 0;
    rows_q.delete();
    for (int i = 0; i < 700 && !done; i++) begin
      sb_cycle(1);
      len++;
      if (vblank_n === 1'b1) begin
        vis++;
        if (line == 4'd0) rows_q.push_back(int'(row));
      end
      done = (frame_start === 1'b1);
      sb_cycle(0);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; rst2_n = 0; hs_tick = 0; hs2 = 0; mode60 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({vblank_n, vsync_n, row, line, frame_start} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_dut: got vb=%b vs=%b row=%0d line=%0d fs=%b, expected 0 1 0 0 0",
               vblank_n, vsync_n, row, line, frame_start);
    end
    n_vec++;
    if ({vb2, vs2, row2, line2, fs2} !== {1'b0, 1'b1, 5'd0, 4'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_dut2: got vb=%b vs=%b row=%0d line=%0d fs=%b, expected 0 1 0 0 0",
               vb2, vs2, row2, line2, fs2);
    end
    @(negedge clk);
    rst_n = 1; rst2_n = 1;
  endtask

  task automatic test_first_row();
    repeat (13) begin sb_cycle(1); sb_cycle(0); end
    n_vec++;
    if (vsync_n !== 1'b1) begin
      n_miss++;
      $display("FAIL first_row_pre: vsync_n=%b after 13 ticks, expected 1", vsync_n);
    end
    sb_cycle(1);
    n_vec++;
    if (vblank_n !== 1'b0 || vsync_n !== 1'b0) begin
      n_miss++;
      $display("FAIL first_row: vb=%b vs=%b after 14 ticks, expected vb=0 vs=0", vblank_n, vsync_n);
    end
    sb_cycle(0);
  endtask

  task automatic test_frame_50();
    int len, vis, bad;
    sync_frame();
    measure_frame(len, vis);
    n_vec++;
    if (len != 308) begin
      n_miss++;
      $display("FAIL frame50_len: got %0d lines, expected 308", len);
    end
    n_vec++;
    if (vis != 224) begin
      n_miss++;
      $display("FAIL frame50_visible: got %0d lines, expected 224", vis);
    end
    bad = (rows_q.size() != 16) ? 1 : 0;
    for (int i = 0; i < rows_q.size() && i < 16; i++)
      if (rows_q[i] != (15 + i) % 16) bad = 1;
    n_vec++;
    if (bad) begin
      n_miss++;
      $display("FAIL frame50_rows: got %0d rows starting %0d, expected 16 rows 15,0..14",
               rows_q.size(), (rows_q.size() > 0) ? rows_q[0] : -1);
    end
  endtask

  task automatic test_mode_switch();
    int len, vis;
    bit sw = 0;
    bit done = 0;
    len = 0;
    for (int i = 0; i < 700 && !done; i++) begin
      if (!sw && vblank_n === 1'b1 && row == 4'd10) begin
        mode60 = 1;
        sw = 1;
      end
      sb_cycle(1);
      len++;
      done = (frame_start === 1'b1);
      sb_cycle(0);
    end
    n_vec++;
    if (!sw || len != 308) begin
      n_miss++;
      $display("FAIL mode_cur_frame: switched=%0d len=%0d, expected switched=1 len=308", sw, len);
    end
    measure_frame(len, vis);
    n_vec++;
    if (len != 266) begin
      n_miss++;
      $display("FAIL mode_next_frame: got %0d lines, expected 266", len);
    end
    n_vec++;
    if (vis != 196) begin
      n_miss++;
      $display("FAIL mode_next_visible: got %0d lines, expected 196", vis);
    end
    mode60 = 0;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      sb_cycle(1);
      if (vblank_n === 1'b1 && row == 4'd12 && line == 4'd7) found = 1;
      else sb_cycle(0);
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL areset_find: row 12 line 7 not reached, required");
    end
    rst_n = 0;
    #2;
    n_vec++;
    if ({vblank_n, vsync_n, row, line, frame_start} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL areset_immediate: got vb=%b vs=%b row=%0d line=%0d fs=%b, expected 0 1 0 0 0",
               vblank_n, vsync_n, row, line, frame_start);
    end
    hs_tick = 0;
    model_reset();
    repeat (2) sb_cycle(0);
    @(negedge clk);
    rst_n = 1;
    repeat (69) begin sb_cycle(1); sb_cycle(0); end
    sb_cycle(1);
    n_vec++;
    if (vblank_n !== 1'b1 || row !== 4'd15 || line !== 4'd0) begin
      n_miss++;
      $display("FAIL areset_restart: got vb=%b row=%0d line=%0d, expected vb=1 row=15 line=0",
               vblank_n, row, line);
    end
    sb_cycle(0);
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      sb_cycle(1);
      sb_cycle(0);
      found = (vblank_n === 1'b1 && row == 4'd3 && line == 4'd12);
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL b2b_find: row 3 line 12 not reached, required");
    end
    sb_cycle(1);
    n_vec++;
    if (line !== 4'd13 || row !== 4'd3) begin
      n_miss++;
      $display("FAIL b2b_tick1: got row=%0d line=%0d, expected row=3 line=13", row, line);
    end
    sb_cycle(1);
    n_vec++;
    if (line !== 4'd0 || row !== 4'd4) begin
      n_miss++;
      $display("FAIL b2b_tick2: got row=%0d line=%0d, expected row=4 line=0", row, line);
    end
    sb_cycle(1);
    n_vec++;
    if (line !== 4'd1 || row !== 4'd4) begin
      n_miss++;
      $display("FAIL b2b_tick3: got row=%0d line=%0d, expected row=4 line=1", row, line);
    end
    sb_cycle(0);
  endtask

  task automatic t2_cycle(input bit t);
    @(negedge clk);
    hs2 = t;
    @(posedge clk);
    #1;
  endtask

  task automatic test_param_b();
    bit found = 0;
    bit done = 0;
    int len = 0;
    int vis = 0;
    int bad;
    int r2[$];
    for (int i = 0; i < 800 && !found; i++) begin
      t2_cycle(1);
      found = (fs2 === 1'b1);
      t2_cycle(0);
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL alt_sync: no frame_start within 800 lines, required one");
    end
    for (int i = 0; i < 800 && !done; i++) begin
      t2_cycle(1);
      len++;
      if (vb2 === 1'b1) begin
        vis++;
        if (line2 == 4'd0) r2.push_back(int'(row2));
      end
      done = (fs2 === 1'b1);
      t2_cycle(0);
    end
    n_vec++;
    if (len != 310) begin
      n_miss++;
      $display("FAIL alt_len: got %0d lines, expected 310", len);
    end
    n_vec++;
    if (vis != 250) begin
      n_miss++;
      $display("FAIL alt_visible: got %0d lines, expected 250", vis);
    end
    bad = (r2.size() != 25) ? 1 : 0;
    for (int i = 0; i < r2.size() && i < 25; i++)
      if (r2[i] != i) bad = 1;
    n_vec++;
    if (bad) begin
      n_miss++;
      $display("FAIL alt_rows: got %0d rows starting %0d, expected 25 rows 0..24",
               r2.size(), (r2.size() > 0) ? r2[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_frame_50();
    test_mode_switch();
    test_async_reset();
    test_back_to_back();
    test_param_b();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
